axis_pixel_framer: RTL and testbench
====================================

// Module: axis_pixel_framer
// PURPOSE
//  Consumes the raw 8-bit AXI-Stream byte stream produced by the SPI receive stage (no tlast, no tuser).
//  Converts it into a framed video stream for the Sobel pipeline:
//    - tuser marks start-of-frame (SOF); tlast marks end-of-line (EOL).
//    - Column and row counters are driven by the IMG_W/IMG_H geometry.
//  A 2-entry skid buffer on the output gives full throughput and registered ready/valid.
// PARAMETERS
//  DATA_W     8      pixel/byte width
//  IMG_W      640    pixels per line (>=2)
//  IMG_H      480    lines per frame (>=1)
//  SYNC0_P    8'hA5  first sync byte (used only with FRAME_SYNC_EN)
//  SYNC1_P    8'h5A  second sync byte (used only with FRAME_SYNC_EN)
// PORTS
//  clk_i         in   1       core clock
//  rstn_i        in   1       asynchronous active-low reset
//  s_tdata_i     in   DATA_W  input byte from SPI stage
//  s_tvalid_i    in   1       input valid
//  s_tready_o    out  1       input ready
//  m_tdata_o     out  DATA_W  pixel out
//  m_tvalid_o    out  1       pixel valid
//  m_tready_i    in   1       downstream ready
//  m_tuser_o     out  1       SOF: first pixel of frame (col 0, row 0)
//  m_tlast_o     out  1       EOL: pixel at col IMG_W-1
//  frame_done_o  out  1       1-cycle pulse when the last pixel of a frame is accepted on m_*
//  frame_cnt_o   out  16      completed-frame count; wraps 16'hFFFF -> 0
//  sync_err_o    out  1       1-cycle pulse when a sync pattern truncates a frame in progress
// BEHAVIOUR
//  - Reset: all outputs 0 except s_tready_o. Reset clears both counters, frame_cnt_o and the skid buffer.
//  - Reset state of s_tready_o: 0 while rstn_i is low; 1 on the first clock after release.
//  - Reset mid-frame discards all buffered pixels; the next accepted byte is SOF.
//  - Handshake: transfer occurs when valid & ready on the same edge.
//  - Once m_tvalid_o is asserted, m_tdata_o, m_tuser_o and m_tlast_o are held stable until accepted.
//  - Latency: a byte accepted at edge N appears on m_* after edge N (1 cycle) when the buffer is empty.
//  - Skid buffer: 2 entries.
//    - s_tready_o = entry count < 2, registered.
//    - With m_tready_i held 1, sustains 1 pixel/cycle.
//    - When full, s_tready_o = 0 until a pop occurs.
//    - A simultaneous push and pop keeps the count unchanged.
//  - Tagging: tuser/tlast are computed at push time from col/row, then stored with the data.
//  - Counters: col 0..IMG_W-1 and row 0..IMG_H-1, width $clog2 of each limit. They advance on each pixel push.
//    - col == IMG_W-1: col wraps to 0 and row increments.
//    - At (IMG_W-1, IMG_H-1): col and row wrap to (0,0).
//    - frame_done_o pulses and frame_cnt_o increments on the pop of the final pixel.
// CONFIGURATION
//  FRAME_SYNC_EN undefined: every input byte is a pixel. SYNC0_P/SYNC1_P are ignored and sync_err_o is tied 0.
//  FRAME_SYNC_EN defined: a 3-state FSM sits in front of the push logic.
//    PASS  - byte != SYNC0_P: push as pixel.
//          - byte == SYNC0_P: capture it in the hold register, push nothing, go to HOLD.
//    HOLD  - byte == SYNC1_P: drop both bytes and reset col/row to 0; the next pixel carries tuser.
//              If col|row != 0, pulse sync_err_o. Go to PASS.
//          - byte == SYNC0_P: push the held byte as a pixel, keep the new byte held, stay in HOLD.
//          - other byte X: push the held byte, capture X, go to FLUSH.
//    FLUSH - s_tready_o forced 0; push X when space allows, then go to PASS.
//    Reset state: PASS with the hold register cleared.
// TESTING (IMG_W=4, IMG_H=2 unless noted)
//  1. 8 bytes 0x00..0x07 with m_tready_i=1 -> 8 pixels in order.
//     tuser on 0x00 only; tlast on 0x03 and 0x07.
//     frame_done_o pulses once after 0x07; frame_cnt_o=1.
//  2. m_tready_i=0 while 3 bytes are offered -> s_tready_o falls after 2 accepted.
//     Release ready -> all 3 pixels output, none lost or duplicated.
//  3. 17 bytes continuous -> two complete frames, then third-frame pixel 0x10 with tuser=1.
//     Counters wrap with no bubble; frame_cnt_o=2.
//  4. rstn_i low after 3 pixels of a frame, then release and send 0x20.. -> 0x20 carries tuser; frame_cnt_o=0.
//  5. [FRAME_SYNC_EN] Sequence 0x11,0x12,0xA5,0x5A,0x30 -> pixels 0x11,0x12,0x30.
//     sync_err_o pulses once; 0x30 carries tuser.
//  6. [FRAME_SYNC_EN] Sequence 0xA5,0xA5,0x07 -> pixels 0xA5,0xA5,0x07 in order with no sync action.
//     sync_err_o stays 0.

Source files
------------

// File: rtl/axis_pixel_framer_if.sv
// Stream bundle for axis_pixel_framer: raw byte input (s_*) and framed pixel output (m_*).
// The slave modport is the framer's view; master is the view of whatever drives and sinks it.
interface axis_pixel_framer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_tdata_i;
    logic              s_tvalid_i;
    logic              s_tready_o;
    logic [DATA_W-1:0] m_tdata_o;
    logic              m_tvalid_o;
    logic              m_tready_i;
    logic              m_tuser_o;
    logic              m_tlast_o;

    modport slave (
        input  s_tdata_i, s_tvalid_i, m_tready_i,
        output s_tready_o, m_tdata_o, m_tvalid_o, m_tuser_o, m_tlast_o
    );

    modport master (
        output s_tdata_i, s_tvalid_i, m_tready_i,
        input  s_tready_o, m_tdata_o, m_tvalid_o, m_tuser_o, m_tlast_o
    );
endinterface

// File: rtl/axis_pixel_framer.sv
// Frames a raw byte stream into pixels tagged with SOF (tuser) and EOL (tlast) behind a 2-entry skid buffer.
// Define FRAME_SYNC_EN to add the SYNC0_P/SYNC1_P frame-sync detector in front of the push logic.
module axis_pixel_framer #(
    parameter int               DATA_W  = 8,
    parameter int               IMG_W   = 640,
    parameter int               IMG_H   = 480,
    parameter logic [DATA_W-1:0] SYNC0_P = 8'hA5,
    parameter logic [DATA_W-1:0] SYNC1_P = 8'h5A
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    axis_pixel_framer_if.slave        bus,
    output logic                      frame_done_o,
    output logic [15:0]               frame_cnt_o,
    output logic                      sync_err_o
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int ENT_W = DATA_W + 3;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    // entry layout: {eof, tuser, tlast, data}; slot 0 is always the head
    logic [ENT_W-1:0]  r_ent [2];
    logic [1:0]        r_vld;
    logic              r_s_ready;
    logic              r_frame_done;
    logic [15:0]       r_frame_cnt;

    logic              w_acc;
    logic              w_pop;
    logic              w_push;
    logic              w_clr;
    logic              w_flush_nxt;
    logic [DATA_W-1:0] w_push_data;
    logic              w_user;
    logic              w_last;
    logic              w_eof;
    logic              w_slot;
    logic [1:0]        w_cnt;
    logic [1:0]        w_cnt_nxt;
    logic [ENT_W-1:0]  w_ent;

    assign w_acc     = bus.s_tvalid_i & r_s_ready;
    assign w_pop     = r_vld[0] & bus.m_tready_i;
    assign w_cnt     = {1'b0, r_vld[0]} + {1'b0, r_vld[1]};
    assign w_cnt_nxt = w_cnt + {1'b0, w_push} - {1'b0, w_pop};
    assign w_user    = (r_col == '0) && (r_row == '0);
    assign w_last    = (r_col == COL_LAST);
    assign w_eof     = w_last && (r_row == ROW_LAST);
    assign w_ent     = {w_eof, w_user, w_last, w_push_data};
    // a pop in the same cycle shifts slot 1 down, so the new entry lands one slot lower
    assign w_slot    = w_pop ? r_vld[1] : r_vld[0];

`ifdef FRAME_SYNC_EN
    typedef enum logic [1:0] {ST_PASS, ST_HOLD, ST_FLUSH} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_hold;
    logic              r_sync_err;

    always_comb begin
        w_push      = 1'b0;
        w_push_data = bus.s_tdata_i;
        w_clr       = 1'b0;
        w_flush_nxt = 1'b0;
        case (r_state)
            ST_PASS: w_push = w_acc && (bus.s_tdata_i != SYNC0_P);
            ST_HOLD: begin
                w_push_data = r_hold;
                if (w_acc) begin
                    if (bus.s_tdata_i == SYNC1_P) begin
                        w_clr = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_flush_nxt = (bus.s_tdata_i != SYNC0_P);
                    end
                end
            end
            ST_FLUSH: begin
                w_push_data = r_hold;
                w_push      = ~r_vld[1];
                w_flush_nxt = r_vld[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_PASS;
            r_hold     <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_clr && ((r_col != '0) || (r_row != '0));
            case (r_state)
                ST_PASS: if (w_acc && (bus.s_tdata_i == SYNC0_P)) begin
                    r_hold  <= bus.s_tdata_i;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: if (w_acc) begin
                    r_hold <= bus.s_tdata_i;
                    if (bus.s_tdata_i == SYNC1_P)
                        r_state <= ST_PASS;
                    else if (bus.s_tdata_i != SYNC0_P)
                        r_state <= ST_FLUSH;
                end
                ST_FLUSH: if (w_push) r_state <= ST_PASS;
                default: r_state <= ST_PASS;
            endcase
        end
    end

    assign sync_err_o = r_sync_err;
`else
    // sync bytes have no role without the detector; fold them away so they read as intentionally idle
    logic w_unused_sync;
    assign w_unused_sync = ^{SYNC0_P, SYNC1_P};

    assign w_push      = w_acc;
    assign w_push_data = bus.s_tdata_i;
    assign w_clr       = 1'b0;
    assign w_flush_nxt = 1'b0;
    assign sync_err_o  = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_col        <= '0;
            r_row        <= '0;
            r_ent[0]     <= '0;
            r_ent[1]     <= '0;
            r_vld        <= '0;
            r_s_ready    <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_s_ready    <= (w_cnt_nxt < 2'd2) && !w_flush_nxt;
            r_frame_done <= w_pop && r_ent[0][DATA_W+2];
            if (w_pop && r_ent[0][DATA_W+2])
                r_frame_cnt <= r_frame_cnt + 16'd1;

            if (w_clr) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_push) begin
                if (w_last) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_pop) begin
                r_ent[0] <= r_ent[1];
                r_vld    <= {1'b0, r_vld[1]};
            end
            if (w_push) begin
                r_ent[w_slot] <= w_ent;
                r_vld[w_slot] <= 1'b1;
            end
        end
    end

    assign bus.s_tready_o = r_s_ready;
    assign bus.m_tvalid_o = r_vld[0];
    assign bus.m_tdata_o  = r_ent[0][DATA_W-1:0];
    assign bus.m_tlast_o  = r_ent[0][DATA_W];
    assign bus.m_tuser_o  = r_ent[0][DATA_W+1];
    assign frame_done_o   = r_frame_done;
    assign frame_cnt_o    = r_frame_cnt;
endmodule

// File: tb/tb_axis_pixel_framer.sv
// Self-checking bench for axis_pixel_framer (IMG_W=4, IMG_H=2): directed cases plus randomized traffic
// scored against a pixel-index model; sync-detector cases run only when FRAME_SYNC_EN is defined.
`timescale 1ns/1ps
module tb_axis_pixel_framer;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int FRAME = W * H;

    typedef struct {
        logic [7:0] data;
        logic       user;
        logic       last;
        logic       eof;
    } pix_t;

    logic        clk_i  = 1'b0;
    logic        rstn_i = 1'b0;
    logic        frame_done_o;
    logic [15:0] frame_cnt_o;
    logic        sync_err_o;

    axis_pixel_framer_if #(.DATA_W(8)) bus ();

    axis_pixel_framer #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .bus          (bus),
        .frame_done_o (frame_done_o),
        .frame_cnt_o  (frame_cnt_o),
        .sync_err_o   (sync_err_o)
    );

    always #5 clk_i = ~clk_i;

    int   errors = 0;
    int   checks = 0;
    pix_t exp_q[$];
    pix_t cap_q[$];
    int   pos = 0;
    int   frames = 0;
    logic exp_done = 1'b0;
    bit   model_on = 1'b1;
    bit   last_acc = 1'b0;
    int   err_pulses = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: score current outputs, drive new inputs, advance the model, step one clock.
    task automatic cycle(input logic vld, input logic [7:0] dat, input logic rdy);
        pix_t p;
        logic acc;
        logic pop;
        if (model_on) begin
            check_val("s_tready", 32'(bus.s_tready_o), 32'(exp_q.size() < 2));
            check_val("m_tvalid", 32'(bus.m_tvalid_o), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check_val("m_tdata", 32'(bus.m_tdata_o), 32'(exp_q[0].data));
                check_val("m_tuser", 32'(bus.m_tuser_o), 32'(exp_q[0].user));
                check_val("m_tlast", 32'(bus.m_tlast_o), 32'(exp_q[0].last));
            end
            check_val("frame_done", 32'(frame_done_o), 32'(exp_done));
            check_val("frame_cnt", 32'(frame_cnt_o), 32'(frames & 16'hFFFF));
        end else if (sync_err_o) begin
            err_pulses++;
        end
        bus.s_tvalid_i = vld;
        bus.s_tdata_i  = dat;
        bus.m_tready_i = rdy;
        acc = vld & bus.s_tready_o;
        pop = bus.m_tvalid_o & rdy;
        last_acc = acc;
        if (model_on) begin
            exp_done = 1'b0;
            if (pop && exp_q.size() != 0) begin
                p = exp_q.pop_front();
                if (p.eof) begin
                    frames++;
                    exp_done = 1'b1;
                end
            end
            if (acc) begin
                p.data = dat;
                p.user = (pos == 0);
                p.last = ((pos % W) == W - 1);
                p.eof  = (pos == FRAME - 1);
                exp_q.push_back(p);
                pos = (pos + 1) % FRAME;
            end
        end else if (pop) begin
            p.data = bus.m_tdata_o;
            p.user = bus.m_tuser_o;
            p.last = bus.m_tlast_o;
            p.eof  = 1'b0;
            cap_q.push_back(p);
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        rstn_i         = 1'b0;
        bus.s_tvalid_i = 1'b0;
        bus.s_tdata_i  = 8'h00;
        bus.m_tready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_val("rst_s_tready", 32'(bus.s_tready_o), 32'd0);
        check_val("rst_m_tvalid", 32'(bus.m_tvalid_o), 32'd0);
        check_val("rst_m_tuser", 32'(bus.m_tuser_o), 32'd0);
        check_val("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        check_val("rst_frame_done", 32'(frame_done_o), 32'd0);
        exp_q.delete();
        pos      = 0;
        frames   = 0;
        exp_done = 1'b0;
        rstn_i   = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check_val("rst_release_ready", 32'(bus.s_tready_o), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n;
        n = 0;
        do begin
            cycle(1'b1, d, 1'b1);
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) check_val("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int sent;
        int n;
        logic [7:0] rb;
        bus.s_tvalid_i = 1'b0;
        bus.s_tdata_i  = 8'h00;
        bus.m_tready_i = 1'b0;
        do_reset();

        // one full frame at full rate
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i), 1'b1);
        drain(4);
        check_val("t1_frame_cnt", 32'(frame_cnt_o), 32'd1);

        // downstream stall: only two bytes fit, then release
        sent = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(8 + sent), 1'b0);
            if (last_acc) sent++;
        end
        check_val("t2_accepted_stalled", 32'(sent), 32'd2);
        n = 0;
        while (sent < 3 && n < 10) begin
            cycle(1'b1, 8'(8 + sent), 1'b1);
            if (last_acc) sent++;
            n++;
        end
        check_val("t2_accepted_total", 32'(sent), 32'd3);
        drain(4);

        // 17 bytes back to back across two frame boundaries
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b1);
        drain(4);
        check_val("t3_frame_cnt", 32'(frame_cnt_o), 32'd2);

        // reset with pixels buffered mid-frame
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h12, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b1);
        drain(4);
        check_val("t4_frame_cnt", 32'(frame_cnt_o), 32'd1);

        // random traffic; sync bytes avoided so the detector, if built, stays transparent
        for (int i = 0; i < 4000; i++) begin
            rb = 8'($urandom_range(0, 255));
            if (rb == 8'hA5 || rb == 8'h5A) rb = 8'h00;
            if ((i / 200) % 3 == 1)
                cycle(1'($urandom_range(0, 3) != 0), rb, 1'($urandom_range(0, 3) == 0));
            else
                cycle(1'($urandom_range(0, 3) != 0), rb, 1'($urandom_range(0, 3) != 0));
        end
        drain(4);
        check_val("rand_drained", 32'(exp_q.size()), 32'd0);

`ifdef FRAME_SYNC_EN
        // sync pattern truncating a frame
        do_reset();
        model_on   = 1'b0;
        cap_q.delete();
        err_pulses = 0;
        send_byte(8'h11);
        send_byte(8'h12);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'h30);
        drain(4);
        check_val("t5_count", 32'(cap_q.size()), 32'd3);
        if (cap_q.size() == 3) begin
            check_val("t5_px0", 32'(cap_q[0].data), 32'h11);
            check_val("t5_px0_user", 32'(cap_q[0].user), 32'd1);
            check_val("t5_px1", 32'(cap_q[1].data), 32'h12);
            check_val("t5_px1_user", 32'(cap_q[1].user), 32'd0);
            check_val("t5_px2", 32'(cap_q[2].data), 32'h30);
            check_val("t5_px2_user", 32'(cap_q[2].user), 32'd1);
        end
        check_val("t5_sync_err", 32'(err_pulses), 32'd1);

        // repeated SYNC0 followed by a plain byte is all pixels
        cap_q.delete();
        err_pulses = 0;
        send_byte(8'hA5);
        send_byte(8'hA5);
        send_byte(8'h07);
        drain(4);
        check_val("t6_count", 32'(cap_q.size()), 32'd3);
        if (cap_q.size() == 3) begin
            check_val("t6_px0", 32'(cap_q[0].data), 32'hA5);
            check_val("t6_px1", 32'(cap_q[1].data), 32'hA5);
            check_val("t6_px2", 32'(cap_q[2].data), 32'h07);
        end
        check_val("t6_sync_err", 32'(err_pulses), 32'd0);
        model_on = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
